// File: rtl/tile_map_arbiter_if.sv
// Tile-map arbiter bus: video port, game port and RAM port.
// slave = arbiter side, master = requesters and RAM side.
interface tile_map_arbiter_if #(
  parameter int TILE_W = 4
);
  logic              frame_blank;
  logic              vid_req;
  logic [5:0]        vid_row;
  logic [5:0]        vid_col;
  logic [TILE_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              vid_overrun;
  logic              game_req;
  logic              game_we;
  logic [5:0]        game_row;
  logic [5:0]        game_col;
  logic [TILE_W-1:0] game_wdata;
  logic              game_gnt;
  logic [TILE_W-1:0] game_rdata;
  logic              game_rvalid;
  logic              game_err;
  logic              mem_en;
  logic              mem_we;
  logic [10:0]       mem_addr;
  logic [TILE_W-1:0] mem_wdata;
  logic [TILE_W-1:0] mem_rdata;

  modport slave (
    input  frame_blank, vid_req, vid_row, vid_col,
    input  game_req, game_we, game_row, game_col, game_wdata,
    input  mem_rdata,
    output vid_rdata, vid_rvalid, vid_overrun,
    output game_gnt, game_rdata, game_rvalid, game_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output frame_blank, vid_req, vid_row, vid_col,
    output game_req, game_we, game_row, game_col, game_wdata,
    output mem_rdata,
    input  vid_rdata, vid_rvalid, vid_overrun,
    input  game_gnt, game_rdata, game_rvalid, game_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tile_map_arbiter.sv
// Video-priority arbiter for the single-port tile-map RAM.
// TILE_ARB_BLANK_ONLY_EN: game writes only during frame_blank.
module tile_map_arbiter #(
  parameter int TILE_W     = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 64
) (
  input logic               HCLK,
  input logic               HRESETn,
  tile_map_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    T_NONE, T_VID, T_VZERO, T_GAME
  } tag_e;

  localparam logic [10:0] COLS11 = 11'(COLS);
  localparam logic [5:0]  COLS6  = 6'(COLS);
  localparam logic [5:0]  ROWS6  = 6'(ROWS);
  localparam logic [7:0]  SMAX   = 8'(STARVE_MAX);

  logic       pend_v;
  logic [5:0] pend_row;
  logic [5:0] pend_col;
  logic [7:0] cnt;
  logic       overrun_q;
  tag_e       tag_q [0:MEM_LAT];

  logic game_ok;
  logic ovr_ok;
  logic override;
  logic use_pend;
  logic use_new;
  logic game_win;
  logic pend_v_n;
  logic park;
  logic drop;

  logic              sel_v;
  logic              sel_game;
  logic              sel_we;
  logic [5:0]        sel_row;
  logic [5:0]        sel_col;
  logic [TILE_W-1:0] sel_wdata;
  logic              sel_bad;
  tag_e              sel_tag;

`ifdef TILE_ARB_BLANK_ONLY_EN
  assign game_ok = bus.game_req
                 & (~bus.game_we | bus.frame_blank);
  assign ovr_ok  = ~bus.game_we;
`else
  logic blank_unused;
  assign blank_unused = bus.frame_blank;
  assign game_ok = bus.game_req;
  assign ovr_ok  = 1'b1;
`endif

  // Pick one winner and compute pending-slot update
  always_comb begin
    override = game_ok & ovr_ok & (cnt >= SMAX);
    use_pend = pend_v & ~override;
    use_new  = ~override & ~pend_v & bus.vid_req;
    game_win = override
             | (game_ok & ~pend_v & ~bus.vid_req);
    park     = bus.vid_req & (pend_v ^ override);
    drop     = bus.vid_req & pend_v & override;
    pend_v_n = (pend_v & override) | park;
  end

  // Mux the winning request onto the RAM path
  always_comb begin
    sel_v     = use_pend | use_new | game_win;
    sel_game  = game_win;
    sel_we    = 1'b0;
    sel_row   = bus.game_row;
    sel_col   = bus.game_col;
    sel_wdata = bus.game_wdata;
    if (use_pend) begin
      sel_row = pend_row;
      sel_col = pend_col;
    end else if (use_new) begin
      sel_row = bus.vid_row;
      sel_col = bus.vid_col;
    end else if (game_win) begin
      sel_we = bus.game_we;
    end
    sel_bad = (sel_row >= ROWS6) | (sel_col >= COLS6);
    sel_tag = T_NONE;
    if (sel_v & ~sel_game)
      sel_tag = sel_bad ? T_VZERO : T_VID;
    else if (sel_v & ~sel_we & ~sel_bad)
      sel_tag = T_GAME;
  end

  assign bus.game_gnt = game_win;
  assign bus.game_err = game_win & sel_bad;

  // Pending slot, starvation counter, overrun flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_v    <= 1'b0;
      pend_row  <= '0;
      pend_col  <= '0;
      cnt       <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_v <= pend_v_n;
      if (park) begin
        pend_row <= bus.vid_row;
        pend_col <= bus.vid_col;
      end
      if (!bus.game_req || game_win)
        cnt <= '0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      if (drop)
        overrun_q <= 1'b1;
    end
  end

  // Registered RAM command
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= sel_v & ~sel_bad;
      bus.mem_we <= sel_v & sel_we & ~sel_bad;
      if (sel_v & ~sel_bad) begin
        bus.mem_addr  <= 11'(sel_row) * COLS11
                       + 11'(sel_col);
        bus.mem_wdata <= sel_wdata;
      end
    end
  end

  // Owner tag pipeline aligned to read latency
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i <= MEM_LAT; i++)
        tag_q[i] <= T_NONE;
    end else begin
      tag_q[0] <= sel_tag;
      for (int i = 1; i <= MEM_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign bus.vid_rvalid  = (tag_q[MEM_LAT] == T_VID)
                         | (tag_q[MEM_LAT] == T_VZERO);
  assign bus.vid_rdata   = (tag_q[MEM_LAT] == T_VID)
                         ? bus.mem_rdata : '0;
  assign bus.game_rvalid = (tag_q[MEM_LAT] == T_GAME);
  assign bus.game_rdata  = (tag_q[MEM_LAT] == T_GAME)
                         ? bus.mem_rdata : '0;
  assign bus.vid_overrun = overrun_q;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed self-checking bench for tile_map_arbiter.
// Uses a behavioural 1-cycle-latency RAM.
module tb_tile_map_arbiter;

  logic HCLK;
  logic HRESETn;
  int   tests;
  int   fails;

  tile_map_arbiter_if #(.TILE_W(4)) bus ();

  tile_map_arbiter dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  logic [3:0] ram [0:1199];
  logic [3:0] rdata_q;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        ram[bus.mem_addr] <= bus.mem_wdata;
      rdata_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic idle();
    bus.vid_req  = 1'b0;
    bus.game_req = 1'b0;
    bus.game_we  = 1'b0;
  endtask

  task automatic test_reset();
    smp();
    tests++;
    if (bus.mem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_mem_en got %b want 0", bus.mem_en);
    end
    tests++;
    if (bus.vid_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_overrun got %b want 0",
               bus.vid_overrun);
    end
    tests++;
    if ({bus.vid_rvalid, bus.game_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_rvalid got %b%b want 00",
               bus.vid_rvalid, bus.game_rvalid);
    end
  endtask

  task automatic test_game_read();
    cyc();
    bus.game_req = 1'b1;
    bus.game_we  = 1'b0;
    bus.game_row = 6'd5;
    bus.game_col = 6'd7;
    smp();
    tests++;
    if (bus.game_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rd_gnt got %b want 1", bus.game_gnt);
    end
    cyc();
    idle();
    smp();
    tests++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 11'd207
        || bus.mem_we !== 1'b0) begin
      fails++;
      $display("FAIL rd_cmd got en=%b we=%b addr=%0d want 1 0 207",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    cyc();
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 4'hA
        || bus.vid_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rd_data got v=%b d=%h want 1 a",
               bus.game_rvalid, bus.game_rdata);
    end
  endtask

  task automatic test_collision();
    cyc();
    bus.vid_req  = 1'b1;
    bus.vid_row  = 6'd1;
    bus.vid_col  = 6'd2;
    bus.game_req = 1'b1;
    bus.game_we  = 1'b0;
    bus.game_row = 6'd0;
    bus.game_col = 6'd0;
    smp();
    tests++;
    if (bus.game_gnt !== 1'b0) begin
      fails++;
      $display("FAIL col_gnt0 got %b want 0", bus.game_gnt);
    end
    cyc();
    bus.vid_req = 1'b0;
    smp();
    tests++;
    if (bus.game_gnt !== 1'b1 || bus.mem_addr !== 11'd42) begin
      fails++;
      $display("FAIL col_gnt1 got gnt=%b addr=%0d want 1 42",
               bus.game_gnt, bus.mem_addr);
    end
    cyc();
    idle();
    smp();
    tests++;
    if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 4'h5
        || bus.mem_addr !== 11'd0) begin
      fails++;
      $display("FAIL col_vid got v=%b d=%h addr=%0d want 1 5 0",
               bus.vid_rvalid, bus.vid_rdata, bus.mem_addr);
    end
    cyc();
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 4'h3
        || bus.vid_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL col_game got v=%b d=%h want 1 3",
               bus.game_rvalid, bus.game_rdata);
    end
  endtask

  task automatic test_starvation();
    int gcyc;
    gcyc = -1;
    bus.vid_row  = 6'd0;
    bus.vid_col  = 6'd1;
    bus.game_we  = 1'b0;
    bus.game_row = 6'd2;
    bus.game_col = 6'd3;
    for (int c = 0; c <= 66; c++) begin
      cyc();
      bus.vid_req  = (c <= 65);
      bus.game_req = (gcyc < 0);
      smp();
      if (bus.game_gnt && gcyc < 0)
        gcyc = c;
      if (c == 65) begin
        tests++;
        if (bus.mem_addr !== 11'd83) begin
          fails++;
          $display("FAIL stv_game_addr got %0d want 83",
                   bus.mem_addr);
        end
      end
      if (c == 66) begin
        tests++;
        if (bus.mem_addr !== 11'd1 || bus.mem_en !== 1'b1) begin
          fails++;
          $display("FAIL stv_park_addr got en=%b addr=%0d want 1 1",
                   bus.mem_en, bus.mem_addr);
        end
      end
    end
    tests++;
    if (gcyc !== 64) begin
      fails++;
      $display("FAIL stv_gnt_cycle got %0d want 64", gcyc);
    end
    cyc();
    idle();
    cyc();
    smp();
    tests++;
    if (bus.vid_overrun !== 1'b0) begin
      fails++;
      $display("FAIL stv_overrun got %b want 0", bus.vid_overrun);
    end
  endtask

  task automatic test_overrun();
    int g1;
    int g2;
    int n;
    g1 = -1;
    g2 = -1;
    n  = 0;
    for (int c = 0; c <= 133; c++) begin
      cyc();
      bus.vid_req  = (c <= 131);
      bus.game_req = (c <= 129);
      smp();
      if (bus.game_gnt) begin
        n++;
        if (g1 < 0)
          g1 = c;
        else
          g2 = c;
      end
      if (c == 129) begin
        tests++;
        if (bus.vid_overrun !== 1'b0) begin
          fails++;
          $display("FAIL ovr_early got %b want 0",
                   bus.vid_overrun);
        end
      end
      if (c == 130 || c == 133) begin
        tests++;
        if (bus.vid_overrun !== 1'b1) begin
          fails++;
          $display("FAIL ovr_set c=%0d got %b want 1",
                   c, bus.vid_overrun);
        end
      end
    end
    tests++;
    if (g1 !== 64 || g2 !== 129 || n !== 2) begin
      fails++;
      $display("FAIL ovr_gnts got %0d,%0d n=%0d want 64,129 n=2",
               g1, g2, n);
    end
    idle();
  endtask

  task automatic test_range();
    cyc();
    bus.frame_blank = 1'b1;
    bus.game_req    = 1'b1;
    bus.game_we     = 1'b1;
    bus.game_row    = 6'd0;
    bus.game_col    = 6'd40;
    bus.game_wdata  = 4'h7;
    smp();
    tests++;
    if (bus.game_gnt !== 1'b1 || bus.game_err !== 1'b1) begin
      fails++;
      $display("FAIL rng_err got gnt=%b err=%b want 1 1",
               bus.game_gnt, bus.game_err);
    end
    cyc();
    idle();
    bus.frame_blank = 1'b0;
    smp();
    tests++;
    if (bus.mem_en !== 1'b0 || bus.game_err !== 1'b0) begin
      fails++;
      $display("FAIL rng_noacc got en=%b err=%b want 0 0",
               bus.mem_en, bus.game_err);
    end
    bus.vid_req = 1'b1;
    bus.vid_row = 6'd30;
    bus.vid_col = 6'd0;
    cyc();
    idle();
    smp();
    tests++;
    if (bus.mem_en !== 1'b0) begin
      fails++;
      $display("FAIL rng_vid_en got %b want 0", bus.mem_en);
    end
    cyc();
    smp();
    tests++;
    if (bus.vid_rvalid !== 1'b1 || bus.vid_rdata !== 4'h0) begin
      fails++;
      $display("FAIL rng_vid got v=%b d=%h want 1 0",
               bus.vid_rvalid, bus.vid_rdata);
    end
    cyc();
    bus.game_req = 1'b1;
    bus.game_row = 6'd29;
    bus.game_col = 6'd39;
    smp();
    cyc();
    idle();
    smp();
    tests++;
    if (bus.mem_addr !== 11'd1199 || bus.mem_en !== 1'b1) begin
      fails++;
      $display("FAIL rng_max_addr got en=%b addr=%0d want 1 1199",
               bus.mem_en, bus.mem_addr);
    end
    cyc();
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 4'hF) begin
      fails++;
      $display("FAIL rng_max_data got v=%b d=%h want 1 f",
               bus.game_rvalid, bus.game_rdata);
    end
  endtask

  task automatic test_game_write();
    cyc();
    bus.frame_blank = 1'b1;
    bus.game_req    = 1'b1;
    bus.game_we     = 1'b1;
    bus.game_row    = 6'd3;
    bus.game_col    = 6'd4;
    bus.game_wdata  = 4'h9;
    smp();
    tests++;
    if (bus.game_gnt !== 1'b1) begin
      fails++;
      $display("FAIL wr_gnt got %b want 1", bus.game_gnt);
    end
    cyc();
    idle();
    bus.frame_blank = 1'b0;
    smp();
    tests++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1
        || bus.mem_addr !== 11'd124 || bus.mem_wdata !== 4'h9) begin
      fails++;
      $display("FAIL wr_cmd got en=%b we=%b a=%0d d=%h want 1 1 124 9",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    bus.game_req = 1'b1;
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b0 || bus.mem_we !== 1'b0) begin
      fails++;
      $display("FAIL wr_norv got rv=%b we=%b want 0 0",
               bus.game_rvalid, bus.mem_we);
    end
    cyc();
    idle();
    cyc();
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 4'h9) begin
      fails++;
      $display("FAIL wr_readback got v=%b d=%h want 1 9",
               bus.game_rvalid, bus.game_rdata);
    end
  endtask

`ifdef TILE_ARB_BLANK_ONLY_EN
  task automatic test_blank_only();
    int ng;
    int nwe;
    ng = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      bus.frame_blank = 1'b0;
      bus.game_req    = 1'b1;
      bus.game_we     = 1'b1;
      bus.game_row    = 6'd4;
      bus.game_col    = 6'd4;
      bus.game_wdata  = 4'h6;
      smp();
      if (bus.game_gnt)
        ng++;
    end
    tests++;
    if (ng !== 0) begin
      fails++;
      $display("FAIL blk_nognt got %0d grants want 0", ng);
    end
    cyc();
    bus.frame_blank = 1'b1;
    smp();
    tests++;
    if (bus.game_gnt !== 1'b1) begin
      fails++;
      $display("FAIL blk_gnt got %b want 1", bus.game_gnt);
    end
    nwe = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      idle();
      smp();
      if (bus.mem_we)
        nwe++;
    end
    bus.frame_blank = 1'b0;
    tests++;
    if (nwe !== 1) begin
      fails++;
      $display("FAIL blk_we got %0d write cycles want 1", nwe);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    cyc();
    bus.game_req = 1'b1;
    bus.game_we  = 1'b0;
    bus.game_row = 6'd1;
    bus.game_col = 6'd1;
    cyc();
    idle();
    #1;
    HRESETn = 1'b0;
    smp();
    tests++;
    if (bus.mem_en !== 1'b0 || bus.vid_overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst got en=%b ovr=%b want 0 0",
               bus.mem_en, bus.vid_overrun);
    end
    cyc();
    HRESETn = 1'b1;
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rv got %b want 0", bus.game_rvalid);
    end
    cyc();
    smp();
    tests++;
    if (bus.game_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rv2 got %b want 0", bus.game_rvalid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rdata_q = 4'h0;
    for (int i = 0; i < 1200; i++)
      ram[i] = 4'(i * 7);
    ram[207]  = 4'hA;
    ram[42]   = 4'h5;
    ram[0]    = 4'h3;
    ram[1199] = 4'hF;
    HRESETn         = 1'b0;
    bus.frame_blank = 1'b0;
    bus.vid_req     = 1'b0;
    bus.vid_row     = '0;
    bus.vid_col     = '0;
    bus.game_req    = 1'b0;
    bus.game_we     = 1'b0;
    bus.game_row    = '0;
    bus.game_col    = '0;
    bus.game_wdata  = '0;
    test_reset();
    cyc();
    HRESETn = 1'b1;
    test_game_read();
    test_collision();
    test_starvation();
    test_overrun();
    cyc();
    cyc();
    test_range();
    test_game_write();
`ifdef TILE_ARB_BLANK_ONLY_EN
    test_blank_only();
`endif
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
